// File: rtl/queue_fifo_ctrl.sv
// Single-clock FIFO queue with occupancy count, almost-full/empty flags, sync flush and registered read.
// Define QUEUE_ERR_EN to add sticky overflow/underflow outputs.
`timescale 1ns/1ps
module queue_fifo_ctrl #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = 12,
    parameter int AE_LEVEL = 2,
    localparam int PW      = $clog2(DEPTH),
    localparam int CW      = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enq,
    input  logic [WIDTH-1:0] data_in,
    input  logic             deq,
    input  logic             flush,
    output logic [WIDTH-1:0] data_out,
    output logic             dout_valid,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [CW-1:0]    count
`ifdef QUEUE_ERR_EN
    ,
    output logic             overflow,
    output logic             underflow
`endif
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    head, tail;
    logic             enq_ok, deq_ok;

    // Non-power-of-two depths need an explicit wrap rather than natural overflow.
    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        full         = (count == CW'(DEPTH));
        empty        = (count == '0);
        almost_full  = (count >= CW'(AF_LEVEL));
        almost_empty = (count <= CW'(AE_LEVEL));
        enq_ok       = enq && !full;
        deq_ok       = deq && !empty;
    end

    always_ff @(posedge clk) begin
        if (enq_ok && !flush)
            mem[tail] <= data_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            data_out   <= '0;
            dout_valid <= 1'b0;
        end else if (flush) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            dout_valid <= 1'b0;
        end else begin
            dout_valid <= deq_ok;
            if (deq_ok) begin
                data_out <= mem[head];
                head     <= nxt(head);
            end
            if (enq_ok)
                tail <= nxt(tail);
            case ({enq_ok, deq_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef QUEUE_ERR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (flush) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (enq && full)
                overflow <= 1'b1;
            if (deq && empty)
                underflow <= 1'b1;
        end
    end
`endif

endmodule
